ex_muldiv_seq: RTL and testbench

Parametrised iterative multiply/divide unit for the Execute stage, the multi-cycle successor to the single-cycle combinational multiplier path. It accepts one operation through a valid/ready handshake and retires UNROLL bits per cycle. It owns the architectural HI/LO registers, supports multiply-accumulate and multiply-subtract, and raises a one-cycle completion pulse. The pipeline stalls on InReady low and reads Hi/Lo directly.

---
 rtl/ex_muldiv_seq.sv | 193 +++++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative multiply/divide unit with HI/LO, MADD/MSUB, flush
module ex_muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Z,
  output logic             N
);

  localparam int K  = WIDTH / UNROLL;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d, z_q, z_d, n_q, n_d;

  // Operand conditioning at accept: magnitudes plus result signs for signed ops
  logic               in_signed, a_neg, b_neg, accept, is_div_q;
  logic [WIDTH-1:0]   a_abs, b_abs;
  assign in_signed = ~Op[0];
  assign a_neg     = in_signed & A[WIDTH-1];
  assign b_neg     = in_signed & B[WIDTH-1];
  assign a_abs     = a_neg ? -A : A;
  assign b_abs     = b_neg ? -B : B;
  assign accept    = (state_q == S_IDLE) & InValid & ~Flush;
  assign is_div_q  = ~op_q[2] & op_q[1];

  // UNROLL iterations of shift-add (multiply) or restoring shift-subtract (divide).
  // p holds {upper partial, low word}; for divide upper is the remainder, low the quotient.
  logic [2*WIDTH:0]   step, sh;
  logic [WIDTH:0]     upper;
  always_comb begin
    step  = p_q;
    sh    = '0;
    upper = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_div_q) begin
        sh = {step[2*WIDTH-1:0], 1'b0};
        if (sh[2*WIDTH:WIDTH] >= {1'b0, b_q})
          step = {sh[2*WIDTH:WIDTH] - {1'b0, b_q}, sh[WIDTH-1:1], 1'b1};
        else
          step = sh;
      end else begin
        upper = step[0] ? step[2*WIDTH:WIDTH] + {1'b0, b_q} : step[2*WIDTH:WIDTH];
        step  = {1'b0, upper, step[WIDTH-1:1]};
      end
    end
  end

  // Final sign correction, accumulate/subtract against current HI/LO, and flags
  logic [2*WIDTH-1:0] prod_s, acc, mres;
  logic [WIDTH-1:0]   q_s, r_s, hi_fix, lo_fix;
  logic               z_fix, n_fix, dz_fix;
  always_comb begin
    prod_s = neg_res_q ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
    acc    = {hi_q, lo_q};
    mres   = prod_s;
    if (op_q[2]) mres = op_q[1] ? acc - prod_s : acc + prod_s;
    q_s    = neg_res_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    r_s    = neg_rem_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    dz_fix = is_div_q & (b_q == '0);
    if (is_div_q) begin
      lo_fix = dz_fix ? '1 : q_s;
      hi_fix = r_s;
      z_fix  = (lo_fix == '0);
      n_fix  = ~op_q[0] & lo_fix[WIDTH-1];
    end else begin
      {hi_fix, lo_fix} = mres;
      z_fix  = (mres == '0);
      n_fix  = ~op_q[0] & mres[2*WIDTH-1];
    end
  end

  // Next-state, operand capture, HI/LO updates and completion pulse
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b_d       = b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    z_d       = 1'b0;
    n_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (WrHi) hi_d = WrData;
        if (WrLo) lo_d = WrData;
        if (accept) begin
          state_d   = S_RUN;
          op_d      = Op;
          b_d       = b_abs;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = CW'(K);
          p_d       = {{(WIDTH+1){1'b0}}, a_abs};
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          p_d   = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          hi_d   = hi_fix;
          lo_d   = lo_fix;
          done_d = 1'b1;
          dz_d   = dz_fix;
          z_d    = z_fix;
          n_d    = n_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, async active-low reset discards in-flight work
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      b_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      p_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      z_q       <= z_d;
      n_q       <= n_d;
    end
  end

  assign InReady = (state_q == S_IDLE);
  assign Busy    = (state_q != S_IDLE);
  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Z       = z_q;
  assign N       = n_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - directed self-checking bench for ex_muldiv_seq
module tb_ex_muldiv_seq;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        iv1 = 0, fl1 = 0, whi1 = 0, wlo1 = 0;
  logic [2:0]  op1 = 0;
  logic [31:0] a1 = 0, b1 = 0, wd1 = 0;
  logic        rdy1, busy1, done1, dz1, z1, n1;
  logic [31:0] hi1, lo1;

  logic        iv2 = 0, fl2 = 0, whi2 = 0, wlo2 = 0;
  logic [2:0]  op2 = 0;
  logic [31:0] a2 = 0, b2 = 0, wd2 = 0;
  logic        rdy2, busy2, done2, dz2, z2, n2;
  logic [31:0] hi2, lo2;

  ex_muldiv_seq #(.WIDTH(32), .UNROLL(1)) u1 (
    .clk(clk), .nrst(nrst), .InValid(iv1), .InReady(rdy1), .Op(op1), .A(a1), .B(b1),
    .Flush(fl1), .WrHi(whi1), .WrLo(wlo1), .WrData(wd1), .Hi(hi1), .Lo(lo1),
    .Busy(busy1), .Done(done1), .DivZero(dz1), .Z(z1), .N(n1));

  ex_muldiv_seq #(.WIDTH(32), .UNROLL(4)) u2 (
    .clk(clk), .nrst(nrst), .InValid(iv2), .InReady(rdy2), .Op(op2), .A(a2), .B(b2),
    .Flush(fl2), .WrHi(whi2), .WrLo(wlo2), .WrData(wd2), .Hi(hi2), .Lo(lo2),
    .Busy(busy2), .Done(done2), .DivZero(dz2), .Z(z2), .N(n2));

  int n_pass = 0;
  int n_fail = 0;
  int lat;
  int pulses;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    iv1 = 1; op1 = op; a1 = a; b1 = b;
    tick();
    iv1 = 0;
  endtask

  task automatic wait1(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait2(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (done2) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_hi", hi1, 0);
    check("rst_lo", lo1, 0);
    check("rst_done", done1, 0);
    check("rst_inready", rdy1, 1);
    check("rst_busy", busy1, 0);
    nrst = 1;
    tick();

    // Reset mid-RUN discards work and clears HI/LO
    whi1 = 1; wlo1 = 1; wd1 = 32'h1234;
    tick();
    whi1 = 0; wlo1 = 0;
    check("wr_both_hi", hi1, 32'h1234);
    check("wr_both_lo", lo1, 32'h1234);
    issue1(3'b000, 7, 6);
    tick(); tick(); tick();
    check("midrun_busy", busy1, 1);
    nrst = 0;
    #1;
    check("midrst_hi", hi1, 0);
    check("midrst_lo", lo1, 0);
    check("midrst_inready", rdy1, 1);
    tick();
    nrst = 1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1) pulses++;
    end
    check("midrst_no_done", pulses, 0);

    // MULT -1 * 2
    issue1(3'b000, 32'hFFFFFFFF, 32'h2);
    wait1(lat);
    check("mult_latency", lat, 33);
    check("mult_hi", hi1, 32'hFFFFFFFF);
    check("mult_lo", lo1, 32'hFFFFFFFE);
    check("mult_n", n1, 1);
    check("mult_z", z1, 0);
    check("mult_inready_done", rdy1, 1);
    tick();
    check("done_one_cycle", done1, 0);
    check("n_cleared", n1, 0);

    // MULTU same operands
    issue1(3'b001, 32'hFFFFFFFF, 32'h2);
    wait1(lat);
    check("multu_hi", hi1, 32'h1);
    check("multu_lo", lo1, 32'hFFFFFFFE);
    check("multu_n", n1, 0);

    // DIV -7 / 2
    issue1(3'b010, 32'hFFFFFFF9, 32'h2);
    wait1(lat);
    check("div_lo", lo1, 32'hFFFFFFFD);
    check("div_hi", hi1, 32'hFFFFFFFF);
    check("div_n", n1, 1);
    check("div_dz", dz1, 0);

    // DIVU 7 / 0
    issue1(3'b011, 32'h7, 32'h0);
    wait1(lat);
    check("divz_latency", lat, 33);
    check("divz_lo", lo1, 32'hFFFFFFFF);
    check("divz_hi", hi1, 32'h7);
    check("divz_flag", dz1, 1);

    // DIV INT_MIN / -1
    issue1(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait1(lat);
    check("intmin_lo", lo1, 32'h80000000);
    check("intmin_hi", hi1, 32'h0);
    check("intmin_dz", dz1, 0);

    // MTHI 0, then MTLO 10 in the accept cycle of MADD 3*4
    whi1 = 1; wd1 = 0;
    tick();
    whi1 = 0;
    wlo1 = 1; wd1 = 10;
    issue1(3'b100, 3, 4);
    wlo1 = 0;
    wait1(lat);
    check("madd_hi", hi1, 0);
    check("madd_lo", lo1, 22);
    check("madd_z", z1, 0);

    // MSUBU 5*5 from 22
    issue1(3'b111, 5, 5);
    wait1(lat);
    check("msubu_hi", hi1, 32'hFFFFFFFF);
    check("msubu_lo", lo1, 32'hFFFFFFFD);
    check("msubu_n", n1, 0);

    // MULT 0*x gives Z
    issue1(3'b000, 0, 32'h1234);
    wait1(lat);
    check("zero_z", z1, 1);
    check("zero_lo", lo1, 0);

    // Flush in the 10th RUN cycle of DIV 100/7
    whi1 = 1; wlo1 = 1; wd1 = 32'h55;
    tick();
    whi1 = 0; wlo1 = 0;
    issue1(3'b010, 100, 7);
    for (int i = 0; i < 9; i++) tick();
    fl1 = 1;
    tick();
    fl1 = 0;
    check("flush_busy", busy1, 0);
    check("flush_inready", rdy1, 1);
    check("flush_done", done1, 0);
    check("flush_hi", hi1, 32'h55);
    check("flush_lo", lo1, 32'h55);
    issue1(3'b010, 100, 7);
    wait1(lat);
    check("reissue_lo", lo1, 14);
    check("reissue_hi", hi1, 2);

    // Flush in IDLE blocks accept but not direct write
    fl1 = 1; iv1 = 1; op1 = 3'b000; whi1 = 1; wd1 = 32'h77;
    tick();
    fl1 = 0; iv1 = 0; whi1 = 0;
    check("idleflush_busy", busy1, 0);
    check("idleflush_hi", hi1, 32'h77);

    // UNROLL=4: MULTU 0x10000*0x10000, WrLo while Busy ignored
    iv2 = 1; op2 = 3'b001; a2 = 32'h10000; b2 = 32'h10000;
    tick();
    iv2 = 0;
    wlo2 = 1; wd2 = 32'hDEAD;
    tick();
    wlo2 = 0;
    check("u4_busy", busy2, 1);
    wait2(lat);
    check("u4_latency", lat, 8);
    check("u4_hi", hi2, 1);
    check("u4_lo", lo2, 0);

    // Back-to-back issue in the Done cycle
    iv2 = 1; op2 = 3'b001; a2 = 3; b2 = 5;
    tick();
    iv2 = 0;
    check("b2b_busy", busy2, 1);
    wait2(lat);
    check("b2b_latency", lat, 9);
    check("b2b_lo", lo2, 15);
    check("b2b_hi", hi2, 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
